// File: rtl/fifo_rd_packer.sv
// Purpose : packs NUM_BEATS consecutive FWFT FIFO entries into one wide word; flush emits a partial word early.
// Latency : out_valid rises on the edge after the last pop (or the flush); one word per NUM_BEATS+1 cycles sustained.
// Backpress: while a word waits for out_ready, popping stops and out_data/out_cnt are held; popping restarts the cycle after acceptance.
//
// Ports:
//   rd_clk, rd_rst     read-domain clock, asynchronous active-high reset
//   empty, rd_data     FIFO status and first-word-fall-through head entry
//   rd_en              pop request (combinational, never high while empty)
//   flush              single-cycle request to emit the current partial word
//   out_data, out_cnt  packed word (beat 0 in the LSBs) and its count of valid beats
//   out_valid/out_ready  output handshake
module fifo_rd_packer #(
  parameter int DATA_W    = 4,
  parameter int NUM_BEATS = 4,
  parameter int CNT_W     = $clog2(NUM_BEATS + 1)
) (
  input  logic                        rd_clk,
  input  logic                        rd_rst,
  input  logic                        empty,
  input  logic [DATA_W-1:0]           rd_data,
  output logic                        rd_en,
  input  logic                        flush,
  output logic [DATA_W*NUM_BEATS-1:0] out_data,
  output logic [CNT_W-1:0]            out_cnt,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int WORD_W = DATA_W * NUM_BEATS;

  if (NUM_BEATS < 2 || NUM_BEATS > 16) begin : g_bad_num_beats
    $error("fifo_rd_packer: NUM_BEATS must be within 2..16");
  end

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t             state_q, state_nxt;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_nxt;
  logic [WORD_W-1:0]  sreg_q, sreg_nxt;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_nxt;
  logic               pop;
  logic               last_beat;
  logic               emit;

  // Gated by reset so the FIFO is never popped while this block is held in reset.
  assign pop       = (state_q == FILL) & ~empty & ~rd_rst;
  assign rd_en     = pop;

  // The shift register doubles as the output word: it is only written in FILL
  // and only cleared on acceptance, so it is naturally stable during HOLD and
  // any beats not filled before a flush are still zero.
  assign out_data  = sreg_q;
  assign out_cnt   = out_cnt_q;
  assign out_valid = (state_q == HOLD);

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_q    <= FILL;
      beat_cnt_q <= '0;
      sreg_q     <= '0;
      out_cnt_q  <= '0;
    end else begin
      state_q    <= state_nxt;
      beat_cnt_q <= beat_cnt_nxt;
      sreg_q     <= sreg_nxt;
      out_cnt_q  <= out_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state_q;
    beat_cnt_nxt = beat_cnt_q;
    sreg_nxt     = sreg_q;
    out_cnt_nxt  = out_cnt_q;
    last_beat    = 1'b0;
    emit         = 1'b0;

    case (state_q)
      FILL: begin
        if (pop) begin
          for (int b = 0; b < NUM_BEATS; b++) begin
            if (beat_cnt_q == CNT_W'(b)) begin
              sreg_nxt[b*DATA_W +: DATA_W] = rd_data;
            end
          end
          beat_cnt_nxt = beat_cnt_q + CNT_W'(1);
        end

        last_beat = pop && (beat_cnt_q == CNT_W'(NUM_BEATS - 1));
        // A flush with nothing held and nothing arriving has no word to emit.
        emit      = last_beat || (flush && (pop || (beat_cnt_q != '0)));

        if (emit) begin
          state_nxt    = HOLD;
          beat_cnt_nxt = '0;
          // Count includes a beat popped in this same cycle.
          out_cnt_nxt  = beat_cnt_q + CNT_W'(pop);
        end
      end

      HOLD: begin
        // flush is deliberately not looked at here and is not remembered.
        if (out_ready) begin
          state_nxt   = FILL;
          sreg_nxt    = '0;
          out_cnt_nxt = '0;
        end
      end

      default: begin
        state_nxt = FILL;
      end
    endcase
  end

endmodule

// File: tb/tb_fifo_rd_packer.sv
module tb_fifo_rd_packer;

  localparam int DATA_W    = 4;
  localparam int NUM_BEATS = 4;
  localparam int CNT_W     = $clog2(NUM_BEATS + 1);
  localparam int WORD_W    = DATA_W * NUM_BEATS;

  logic               rd_clk = 1'b0;
  logic               rd_rst;
  logic               empty;
  logic [DATA_W-1:0]  rd_data;
  logic               rd_en;
  logic               flush;
  logic [WORD_W-1:0]  out_data;
  logic [CNT_W-1:0]   out_cnt;
  logic               out_valid;
  logic               out_ready;

  fifo_rd_packer #(
    .DATA_W   (DATA_W),
    .NUM_BEATS(NUM_BEATS)
  ) dut (
    .rd_clk   (rd_clk),
    .rd_rst   (rd_rst),
    .empty    (empty),
    .rd_data  (rd_data),
    .rd_en    (rd_en),
    .flush    (flush),
    .out_data (out_data),
    .out_cnt  (out_cnt),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 rd_clk = ~rd_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the FIFO contents, the list of beats gathered so far,
  // and the word currently offered downstream (if any).
  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] m_beats[$];
  bit                m_hold;
  logic [WORD_W-1:0] m_word;
  int                m_cnt;

  // Words the DUT actually handed off (sampled on accepted handshakes).
  logic [WORD_W-1:0] dut_words[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [WORD_W-1:0] pack_beats();
    logic [WORD_W-1:0] w;
    w = '0;
    for (int i = 0; i < m_beats.size(); i++) begin
      w[i*DATA_W +: DATA_W] = m_beats[i];
    end
    return w;
  endfunction

  task automatic model_step(input logic e, input logic f, input logic r, input logic [DATA_W-1:0] d);
    if (!m_hold) begin
      if (!e) begin
        m_beats.push_back(d);
        void'(fifo_q.pop_front());
      end
      if (m_beats.size() == NUM_BEATS || (f && m_beats.size() > 0)) begin
        m_word = pack_beats();
        m_cnt  = m_beats.size();
        m_hold = 1'b1;
        m_beats.delete();
      end
    end else if (r) begin
      m_hold = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_beats.delete();
    m_hold = 1'b0;
    m_word = '0;
    m_cnt  = 0;
  endtask

  // One clock: drive at negedge, check just after, advance model at posedge.
  task automatic cycle(input int stall_pct, input int flush_pct, input int rdy_pct, input int fill_pct);
    @(negedge rd_clk);
    empty     = (fifo_q.size() == 0) || (int'($urandom_range(99)) < stall_pct);
    rd_data   = empty ? DATA_W'($urandom) : fifo_q[0];
    flush     = int'($urandom_range(99)) < flush_pct;
    out_ready = int'($urandom_range(99)) < rdy_pct;
    #1;
    chk("rd_en", rd_en, !m_hold && !empty);
    chk("out_valid", out_valid, m_hold);
    if (m_hold) begin
      chk("out_data", out_data, m_word);
      chk("out_cnt", out_cnt, m_cnt);
    end
    if (out_valid && out_ready) dut_words.push_back(out_data);
    @(posedge rd_clk);
    model_step(empty, flush, out_ready, rd_data);
    if (int'($urandom_range(99)) < fill_pct && fifo_q.size() < 32) begin
      fifo_q.push_back(DATA_W'($urandom));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, rd_en, 1'b0);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_data"}, out_data, '0);
    chk({tag, "_out_cnt"}, out_cnt, '0);
  endtask

  task automatic chk_last_word(input string tag, input logic [WORD_W-1:0] exp);
    if (dut_words.size() == 0) begin
      chk({tag, "_present"}, 0, 1);
    end else begin
      chk(tag, dut_words[dut_words.size()-1], exp);
    end
  endtask

  initial begin
    rd_rst    = 1'b1;
    empty     = 1'b0;   // FIFO claims data: rd_en must still stay low in reset
    rd_data   = 4'h9;
    flush     = 1'b0;
    out_ready = 1'b0;
    model_reset();

    #12;
    chk_reset_outputs("reset");
    @(posedge rd_clk);
    #2;
    rd_rst = 1'b0;
    empty  = 1'b1;
    @(posedge rd_clk);

    // Back-to-back 1..8 with out_ready high: two full words.
    for (int i = 1; i <= 8; i++) fifo_q.push_back(DATA_W'(i));
    for (int c = 0; c < 12; c++) cycle(0, 0, 100, 0);
    chk("words_1to8", dut_words.size(), 2);
    if (dut_words.size() >= 2) begin
      chk("word0", dut_words[0], 16'h4321);
      chk("word1", dut_words[1], 16'h8765);
    end

    // Backpressure: 5..8 again with out_ready low for a while.
    for (int i = 5; i <= 8; i++) fifo_q.push_back(DATA_W'(i));
    fifo_q.push_back(4'h1);
    for (int c = 0; c < 4; c++) cycle(0, 0, 100, 0);
    for (int c = 0; c < 10; c++) cycle(0, 0, 0, 0);
    for (int c = 0; c < 3; c++) cycle(0, 0, 100, 0);
    chk_last_word("word_bp", 16'h8765);
    // Drain the trailing entry so the next directed cases start clean.
    cycle(0, 100, 100, 0);
    cycle(0, 0, 100, 0);

    // Partial word by flush after A,B with the FIFO running dry.
    fifo_q.push_back(4'hA);
    fifo_q.push_back(4'hB);
    cycle(0, 0, 100, 0);
    cycle(0, 0, 100, 0);
    cycle(0, 100, 100, 0);
    cycle(0, 0, 100, 0);
    chk_last_word("word_flush", 16'h00BA);
    // Flush with nothing held and nothing arriving: must emit nothing.
    for (int c = 0; c < 3; c++) cycle(0, 100, 100, 0);

    // Flush in the same cycle as the second pop.
    fifo_q.push_back(4'hC);
    fifo_q.push_back(4'hD);
    cycle(0, 0, 100, 0);
    cycle(0, 100, 100, 0);
    cycle(0, 0, 100, 0);
    chk_last_word("word_flush_pop", 16'h00DC);

    // Randomised traffic: stalls, flushes, backpressure, refills.
    for (int c = 0; c < 2000; c++) cycle(30, 8, 60, 55);
    for (int c = 0; c < 1000; c++) cycle(50, 2, 90, 70);
    for (int c = 0; c < 20; c++) cycle(0, 0, 100, 0);

    // Asynchronous reset mid-cycle after two beats of a new word.
    fifo_q.delete();
    fifo_q.push_back(4'h3);
    fifo_q.push_back(4'h9);
    cycle(0, 0, 100, 0);
    cycle(0, 0, 100, 0);
    #3;
    rd_rst  = 1'b1;
    empty   = 1'b0;
    rd_data = 4'h7;
    #1;
    chk_reset_outputs("midreset");
    model_reset();
    @(posedge rd_clk);
    #2;
    rd_rst = 1'b0;
    empty  = 1'b1;

    fifo_q.delete();
    fifo_q.push_back(4'hE);
    fifo_q.push_back(4'hF);
    fifo_q.push_back(4'h0);
    fifo_q.push_back(4'h1);
    for (int c = 0; c < 6; c++) cycle(0, 0, 100, 0);
    chk_last_word("word_after_reset", 16'h10FE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-domain consumer placed directly downstream of the asynchronous FIFO top.
- Pops DATA_W-bit entries from the FIFO whenever it is non-empty and packs NUM_BEATS consecutive entries into one wide word.
- Presents each packed word on a valid/ready output handshake.
- A flush input forces early emission of a partially filled word.

Parameters:
- DATA_W, 4: width of one FIFO entry (rd_data).
- NUM_BEATS, 4: FIFO entries packed per output word; legal range 2..16.
- CNT_W, $clog2(NUM_BEATS+1): width of out_cnt.

Ports:
- rd_clk  input  1  read-domain clock; all state on its rising edge.
- rd_rst  input  1  asynchronous, active-high reset.
- empty  input  1  FIFO empty flag (already synchronised to rd_clk).
- rd_data  input  DATA_W  FIFO head entry.
- rd_en  output  1  pop request to the FIFO.
- flush  input  1  single-cycle request to emit the current partial word.
- out_data  output  DATA_W*NUM_BEATS  packed word; beat 0 is in bits [DATA_W-1:0].
- out_cnt  output  CNT_W  number of valid beats in out_data (1..NUM_BEATS).
- out_valid  output  1  out_data/out_cnt valid.
- out_ready  input  1  downstream accepts the word.

Behaviour:
- FIFO contract: rd_data is first-word-fall-through, i.e. it shows the head entry combinationally whenever empty=0. A pop occurs on a rising edge with rd_en=1 and empty=0.
- rd_en = (state==FILL) & ~empty. It is combinational and never asserted while empty=1.
- Reset (asynchronous, rd_rst=1):
  - state=FILL, beat_cnt=0, shift register cleared.
  - out_valid=0, out_data=0, out_cnt=0.
  - rd_en=0 while in reset.
  - Any partial word is discarded; entries already popped are lost and not replayed.
- State FILL:
  - On a pop, store rd_data at beat index beat_cnt, then beat_cnt+1.
  - If the pop fills beat NUM_BEATS-1: next state HOLD, out_valid=1, out_cnt=NUM_BEATS, beat_cnt=0.
  - If flush=1 and (beat_cnt>0 or a pop happens this cycle):
    - Next state HOLD, out_valid=1.
    - out_cnt = beat_cnt plus 1 if a pop happens this cycle.
    - A same-cycle pop is included in the emitted word.
    - Unfilled beats read as zero.
  - flush=1 with beat_cnt=0 and no pop: ignored; nothing is emitted.
- State HOLD:
  - rd_en=0. out_data and out_cnt are held stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: out_valid=0, shift register cleared, next state FILL.
  - Popping resumes in the following cycle, not the handshake cycle.
  - flush in HOLD is ignored and not remembered.
- Latency: out_valid rises on the edge after the final pop (or after flush). Sustained throughput is NUM_BEATS+1 cycles per word with out_ready=1.
- empty toggling mid-word only stalls packing; beat order is preserved.
- Arithmetic: beat_cnt wraps only via the explicit reset to 0 on emission and never exceeds NUM_BEATS-1. out_cnt is never 0 while out_valid=1.

Test Plan:
- Reset, then FIFO supplies 1,2,3,4 back-to-back, out_ready=1 → rd_en high for 4 cycles, then out_data=16'h4321, out_cnt=4, out_valid high exactly 1 cycle; rd_en low during HOLD.
- Supply 5,6,7,8 with out_ready=0 for 10 cycles → out_valid held, out_data=16'h8765 stable, rd_en=0 despite empty=0; word accepted on first out_ready cycle, popping resumes next cycle.
- Supply A,B, empty=1, pulse flush → out_data=16'h00BA, out_cnt=2. Flush pulsed with beat_cnt=0 and empty=1 → no out_valid.
- beat_cnt=1 (holding C), flush asserted in the same cycle as popping D → out_data=16'h00DC, out_cnt=2. Flush on the 4th pop → normal full word, out_cnt=4.
- empty toggles every other cycle while 1..8 are supplied → two words, 16'h4321 then 16'h8765. No pop ever occurs with empty=1.
- Assert rd_rst asynchronously after 2 beats, mid-cycle → out_valid/out_data/out_cnt/rd_en drop to 0 immediately. After release, the next 4 entries E,F,0,1 give 16'h10FE.
